// File: rtl/scsi_byte_packer.sv
// Packs the SCSI byte stream into big-endian 32-bit longwords for the DMA FIFO.
// Define PACKER_FLUSH_EN to enable partial-longword flush (FLUSH / FLUSH_DONE).
module scsi_byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_vld_i,
    output logic        byte_rdy_o,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic [31:0] lw_out_o,
    output logic [3:0]  lw_be_o,
    output logic        lw_vld_o,
    input  logic        lw_rdy_i,
    output logic [1:0]  bcnt_o
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [31:0] lw_q;
    logic [3:0]  be_q;
    logic        vld_q;
    logic        flush_pend_q;
    logic        flush_done_q;

    logic        flush_req;
    logic        byte_acc;
    logic        emit;
    logic        lw_hs;
    logic [31:0] lw_pack;
    logic [3:0]  be_pack;

`ifdef PACKER_FLUSH_EN
    assign flush_req = flush_i;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_req    = 1'b0;
`endif

    assign byte_rdy_o = (state_q == StFill) && !flush_pend_q;
    assign byte_acc   = byte_vld_i && byte_rdy_o;
    assign lw_hs      = (state_q == StHold) && vld_q && lw_rdy_i;
    // A flush emits a word only when there is at least one byte to carry.
    assign emit       = (state_q == StFill) &&
                        ((byte_acc && (ptr_q == 2'd3)) ||
                         (flush_req && (byte_acc || (ptr_q != 2'd0))));

    always_comb begin
        lw_pack = lw_q;
        be_pack = be_q;
        if (byte_acc) begin
            unique case (ptr_q)
                2'd0: begin lw_pack[31:24] = byte_in_i; be_pack[3] = 1'b1; end
                2'd1: begin lw_pack[23:16] = byte_in_i; be_pack[2] = 1'b1; end
                2'd2: begin lw_pack[15:8]  = byte_in_i; be_pack[1] = 1'b1; end
                2'd3: begin lw_pack[7:0]   = byte_in_i; be_pack[0] = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFill;
            ptr_q   <= 2'd0;
            lw_q    <= 32'd0;
            be_q    <= 4'd0;
            vld_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= StFill;
            ptr_q   <= 2'd0;
            lw_q    <= 32'd0;
            be_q    <= 4'd0;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (emit) begin
                        lw_q    <= lw_pack;
                        be_q    <= be_pack;
                        vld_q   <= 1'b1;
                        ptr_q   <= 2'd0;
                        state_q <= StHold;
                    end else if (byte_acc) begin
                        lw_q  <= lw_pack;
                        be_q  <= be_pack;
                        ptr_q <= ptr_q + 2'd1;
                    end
                end
                StHold: begin
                    if (lw_hs) begin
                        lw_q    <= 32'd0;
                        be_q    <= 4'd0;
                        vld_q   <= 1'b0;
                        state_q <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

`ifdef PACKER_FLUSH_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else if (clr_i) begin
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (state_q == StFill) begin
                if (flush_req && emit) begin
                    flush_pend_q <= 1'b1;
                end else if (flush_req) begin
                    flush_done_q <= 1'b1;
                end
            end else if (lw_hs) begin
                // The word being handed off satisfies any outstanding flush.
                if (flush_pend_q || flush_req) begin
                    flush_done_q <= 1'b1;
                end
                flush_pend_q <= 1'b0;
            end else if (flush_req) begin
                flush_pend_q <= 1'b1;
            end
        end
    end
`else
    assign flush_pend_q = 1'b0;
    assign flush_done_q = 1'b0;
`endif

    assign flush_done_o = flush_done_q;
    assign lw_out_o     = lw_q;
    assign lw_be_o      = be_q;
    assign lw_vld_o     = vld_q;
    assign bcnt_o       = ptr_q;

endmodule

// File: tb/tb_scsi_byte_packer.sv
// Directed self-checking bench for scsi_byte_packer; flush expectations follow PACKER_FLUSH_EN.
module tb_scsi_byte_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic [7:0]  byte_in_i;
    logic        byte_vld_i;
    logic        byte_rdy_o;
    logic        flush_i;
    logic        flush_done_o;
    logic [31:0] lw_out_o;
    logic [3:0]  lw_be_o;
    logic        lw_vld_o;
    logic        lw_rdy_i;
    logic [1:0]  bcnt_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PACKER_FLUSH_EN
    localparam bit FlushEn = 1'b1;
`else
    localparam bit FlushEn = 1'b0;
`endif

    scsi_byte_packer u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .byte_in_i    (byte_in_i),
        .byte_vld_i   (byte_vld_i),
        .byte_rdy_o   (byte_rdy_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .lw_out_o     (lw_out_o),
        .lw_be_o      (lw_be_o),
        .lw_vld_o     (lw_vld_o),
        .lw_rdy_i     (lw_rdy_i),
        .bcnt_o       (bcnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in_i  = b;
        byte_vld_i = 1'b1;
        step();
        byte_vld_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] lw, input logic [3:0] be);
        check_eq({tag, "_vld"}, {31'd0, lw_vld_o}, 32'd1);
        check_eq({tag, "_lw"}, lw_out_o, lw);
        check_eq({tag, "_be"}, {28'd0, lw_be_o}, {28'd0, be});
    endtask

    initial begin
        rst_ni     = 1'b0;
        clr_i      = 1'b0;
        byte_in_i  = 8'h00;
        byte_vld_i = 1'b0;
        flush_i    = 1'b0;
        lw_rdy_i   = 1'b1;
        #3;
        check_eq("rst_lw", lw_out_o, 32'd0);
        check_eq("rst_be", {28'd0, lw_be_o}, 32'd0);
        check_eq("rst_vld", {31'd0, lw_vld_o}, 32'd0);
        check_eq("rst_done", {31'd0, flush_done_o}, 32'd0);
        check_eq("rst_bcnt", {30'd0, bcnt_o}, 32'd0);
        check_eq("rst_rdy", {31'd0, byte_rdy_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Full word with the FIFO ready.
        send_byte(8'h11);
        check_eq("t1_bcnt1", {30'd0, bcnt_o}, 32'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        check_eq("t1_bcnt3", {30'd0, bcnt_o}, 32'd3);
        send_byte(8'h44);
        check_word("t1", 32'h11223344, 4'hf);
        check_eq("t1_rdy_hold", {31'd0, byte_rdy_o}, 32'd0);
        check_eq("t1_bcnt0", {30'd0, bcnt_o}, 32'd0);
        step();
        check_eq("t1_vld_drop", {31'd0, lw_vld_o}, 32'd0);
        check_eq("t1_lw_clr", lw_out_o, 32'd0);
        check_eq("t1_rdy_back", {31'd0, byte_rdy_o}, 32'd1);

        // Two bytes then flush.
        send_byte(8'hAA);
        send_byte(8'hBB);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        if (FlushEn) begin
            check_word("t2", 32'hAABB0000, 4'hc);
            check_eq("t2_bcnt", {30'd0, bcnt_o}, 32'd0);
            check_eq("t2_done_early", {31'd0, flush_done_o}, 32'd0);
            step();
            check_eq("t2_vld_drop", {31'd0, lw_vld_o}, 32'd0);
            check_eq("t2_done", {31'd0, flush_done_o}, 32'd1);
            step();
            check_eq("t2_done_one", {31'd0, flush_done_o}, 32'd0);
        end else begin
            check_eq("t2_noflush_vld", {31'd0, lw_vld_o}, 32'd0);
            check_eq("t2_noflush_bcnt", {30'd0, bcnt_o}, 32'd2);
            check_eq("t2_noflush_done", {31'd0, flush_done_o}, 32'd0);
            pulse_clr();
        end
        check_eq("t2_bcnt_end", {30'd0, bcnt_o}, 32'd0);

        // Back-pressure: the word must hold while bytes keep arriving.
        lw_rdy_i = 1'b0;
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        byte_in_i  = 8'hEE;
        byte_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_word("t3_hold", 32'hC1C2C3C4, 4'hf);
            check_eq("t3_rdy", {31'd0, byte_rdy_o}, 32'd0);
            step();
        end
        lw_rdy_i = 1'b1;
        step();
        byte_vld_i = 1'b0;
        check_eq("t3_released", {31'd0, lw_vld_o}, 32'd0);
        check_eq("t3_no_byte_on_hs", {30'd0, bcnt_o}, 32'd0);

        // Fourth byte arriving with flush: one full word only.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        flush_i = 1'b1;
        send_byte(8'h04);
        flush_i = 1'b0;
        check_word("t4", 32'h01020304, 4'hf);
        step();
        check_eq("t4_done", {31'd0, flush_done_o}, {31'd0, FlushEn});
        check_eq("t4_vld_drop", {31'd0, lw_vld_o}, 32'd0);
        step();
        check_eq("t4_no_extra", {31'd0, lw_vld_o}, 32'd0);
        check_eq("t4_done_one", {31'd0, flush_done_o}, 32'd0);

        // Flush with nothing held.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("t5_no_vld", {31'd0, lw_vld_o}, 32'd0);
        check_eq("t5_done", {31'd0, flush_done_o}, {31'd0, FlushEn});
        step();
        check_eq("t5_done_one", {31'd0, flush_done_o}, 32'd0);

        // One byte then flush.
        send_byte(8'h77);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        if (FlushEn) begin
            check_word("t5b", 32'h77000000, 4'h8);
            step();
            check_eq("t5b_done", {31'd0, flush_done_o}, 32'd1);
        end else begin
            check_eq("t5b_held_bcnt", {30'd0, bcnt_o}, 32'd1);
            check_eq("t5b_held_vld", {31'd0, lw_vld_o}, 32'd0);
            check_eq("t5b_held_done", {31'd0, flush_done_o}, 32'd0);
            pulse_clr();
        end

        // Flush requested while a word is already waiting.
        lw_rdy_i = 1'b0;
        send_byte(8'hD1);
        send_byte(8'hD2);
        send_byte(8'hD3);
        send_byte(8'hD4);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_word("t5c_hold", 32'hD1D2D3D4, 4'hf);
        lw_rdy_i = 1'b1;
        step();
        check_eq("t5c_done", {31'd0, flush_done_o}, {31'd0, FlushEn});
        check_eq("t5c_rdy", {31'd0, byte_rdy_o}, 32'd1);
        step();

        // Clear drops partial bytes.
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_clr();
        check_eq("t6_clr_bcnt", {30'd0, bcnt_o}, 32'd0);
        check_eq("t6_clr_vld", {31'd0, lw_vld_o}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check_word("t6_clr_word", 32'h01020304, 4'hf);
        step();

        // Asynchronous reset drops partial bytes.
        send_byte(8'h55);
        send_byte(8'h66);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_bcnt", {30'd0, bcnt_o}, 32'd0);
        check_eq("t6_rst_lw", lw_out_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check_word("t6_rst_word", 32'h01020304, 4'hf);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
